// File: rtl/dsp_pkg.sv
`default_nettype none
//==============================================================================
// Package : dsp_pkg
// Desc    : Shared constants and helpers for the packed dual-product unpacker.
//           Macro DSP_UNPACK_SAT_EN selects saturating result conversion.
// Rev     : 1.0
//==============================================================================
package dsp_pkg;

    localparam int SHIFT_DEF = 18;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 24;
    localparam int P_W       = 48;
    localparam int CALC_W    = 64;

    typedef struct packed {
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
    } unpack_t;

    // The high field was formed after the low product was added in, so a
    // negative low field borrowed one from it; adding the low sign restores it.
    function automatic unpack_t unpack(input logic [P_W-1:0] p, input int shift);
        unpack_t           r;
        logic [CALC_W-1:0] lo_raw;
        logic [CALC_W-1:0] hi_raw;
        logic [P_W-1:0]    sgn_vec;
        lo_raw  = {{(CALC_W-P_W){1'b0}}, p} << (CALC_W - shift);
        hi_raw  = {p, {(CALC_W-P_W){1'b0}}};
        sgn_vec = p >> (shift - 1);
        r.lo = $signed(lo_raw) >>> (CALC_W - shift);
        r.hi = ($signed(hi_raw) >>> (CALC_W - P_W + shift))
             + $signed({{(CALC_W-1){1'b0}}, sgn_vec[0]});
        return r;
    endfunction

    function automatic logic [CALC_W-1:0] convert(input logic signed [CALC_W-1:0] v,
                                                  input int out_w);
`ifdef DSP_UNPACK_SAT_EN
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
`else
        return v & ((64'd1 << out_w) - 64'd1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_res_fifo.sv
`default_nettype none
//==============================================================================
// Module : dsp_res_fifo
// Desc   : Synchronous FIFO with fall-through head, push/pop, full/empty flags.
// Rev    : 1.0
//==============================================================================
module dsp_res_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_unpack_acc.sv
`default_nettype none
//==============================================================================
// Module : dsp_unpack_acc
// Desc   : Splits packed dual products, accumulates per window, queues results.
//          DSP_UNPACK_SAT_EN defined: results saturate; otherwise they wrap.
// Rev    : 1.0
//==============================================================================
module dsp_unpack_acc
    import dsp_pkg::*;
#(
    parameter int SHIFT      = SHIFT_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic [P_W-1:0]   I_p,
    input  logic             I_p_valid,
    input  logic             I_first,
    input  logic             I_last,
    output logic [OUT_W-1:0] O_res_l,
    output logic [OUT_W-1:0] O_res_h,
    output logic             O_res_valid,
    input  logic             I_res_ready,
    output logic             O_ovf
);

    unpack_t                 up;
    logic signed [ACC_W-1:0] lo_d;
    logic signed [ACC_W-1:0] hi_d;
    logic signed [ACC_W-1:0] lo_q;
    logic signed [ACC_W-1:0] hi_q;
    logic                    valid_q;
    logic                    first_q;
    logic                    last_q;

    logic signed [ACC_W-1:0] acc_l_q;
    logic signed [ACC_W-1:0] acc_h_q;
    logic signed [ACC_W-1:0] sum_l;
    logic signed [ACC_W-1:0] sum_h;
    logic [OUT_W-1:0]        res_l;
    logic [OUT_W-1:0]        res_h;
    logic                    ovf_q;
    logic                    ovf_d;

    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [2*OUT_W-1:0]      fifo_rdata;

    always_comb begin
        up   = unpack(I_p, SHIFT);
        lo_d = ACC_W'(up.lo);
        hi_d = ACC_W'(up.hi);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lo_q    <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            valid_q <= I_p_valid;
            first_q <= I_p_valid & I_first;
            last_q  <= I_p_valid & I_last;
        end
    end

    // First term restarts the window regardless of any unfinished partial sum.
    always_comb begin
        sum_l = first_q ? lo_q : acc_l_q + lo_q;
        sum_h = first_q ? hi_q : acc_h_q + hi_q;
        res_l = OUT_W'(convert(CALC_W'(sum_l), OUT_W));
        res_h = OUT_W'(convert(CALC_W'(sum_h), OUT_W));
        push  = valid_q & last_q;
        pop   = ~fifo_empty & I_res_ready;
        ovf_d = ovf_q | (push & fifo_full & ~pop);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            acc_l_q <= '0;
            acc_h_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (valid_q) begin
                acc_l_q <= sum_l;
                acc_h_q <= sum_h;
            end
            ovf_q <= ovf_d;
        end
    end

    dsp_res_fifo #(
        .WIDTH (2*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk_i   (I_clk),
        .rst_ni  (I_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({res_h, res_l}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {O_res_h, O_res_l} = fifo_rdata;
    assign O_res_valid        = ~fifo_empty;
    assign O_ovf              = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_unpack_acc.sv
`default_nettype none
//==============================================================================
// Module : tb_dsp_unpack_acc
// Desc   : Directed self-checking bench for dsp_unpack_acc.
// Rev    : 1.0
//==============================================================================
module tb_dsp_unpack_acc;

    logic        I_clk;
    logic        I_rst_n;
    logic [47:0] I_p;
    logic        I_p_valid;
    logic        I_first;
    logic        I_last;
    logic [23:0] O_res_l;
    logic [23:0] O_res_h;
    logic        O_res_valid;
    logic        I_res_ready;
    logic        O_ovf;

    int errors;
    int checks;

    dsp_unpack_acc dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_p         (I_p),
        .I_p_valid   (I_p_valid),
        .I_first     (I_first),
        .I_last      (I_last),
        .O_res_l     (O_res_l),
        .O_res_h     (O_res_h),
        .O_res_valid (O_res_valid),
        .I_res_ready (I_res_ready),
        .O_ovf       (O_ovf)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    function automatic logic [47:0] mkp(input int hi, input int lo);
        return (48'(hi) << 18) + 48'(lo);
    endfunction

    // Present one word for one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input logic [47:0] p, input logic f, input logic l);
        I_p       = p;
        I_p_valid = 1'b1;
        I_first   = f;
        I_last    = l;
        @(posedge I_clk);
        #1;
        I_p_valid = 1'b0;
        I_first   = 1'b0;
        I_last    = 1'b0;
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (O_res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", O_res_valid); end
        checks++; if (O_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", O_ovf); end
        checks++; if (O_res_l !== 24'd0) begin errors++; $display("FAIL rst_res_l: got %0d want 0", O_res_l); end
        checks++; if (O_res_h !== 24'd0) begin errors++; $display("FAIL rst_res_h: got %0d want 0", O_res_h); end
        I_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unpack_pos();
        send(mkp(-10, 15), 1'b1, 1'b1);
        checks++; if (O_res_valid !== 1'b0) begin errors++; $display("FAIL pos_latency: got valid=%b want 0", O_res_valid); end
        tick();
        checks++; if (O_res_valid !== 1'b1) begin errors++; $display("FAIL pos_valid: got %b want 1", O_res_valid); end
        checks++; if ($signed(O_res_l) !== 24'sd15) begin errors++; $display("FAIL pos_res_l: got %0d want 15", $signed(O_res_l)); end
        checks++; if ($signed(O_res_h) !== -24'sd10) begin errors++; $display("FAIL pos_res_h: got %0d want -10", $signed(O_res_h)); end
        tick();
        checks++; if (O_res_valid !== 1'b0) begin errors++; $display("FAIL pos_drain: got valid=%b want 0", O_res_valid); end
    endtask

    task automatic test_unpack_borrow();
        send(mkp(-10, -15), 1'b1, 1'b1);
        tick();
        checks++; if (O_res_valid !== 1'b1) begin errors++; $display("FAIL borrow_valid: got %b want 1", O_res_valid); end
        checks++; if ($signed(O_res_l) !== -24'sd15) begin errors++; $display("FAIL borrow_res_l: got %0d want -15", $signed(O_res_l)); end
        checks++; if ($signed(O_res_h) !== -24'sd10) begin errors++; $display("FAIL borrow_res_h: got %0d want -10", $signed(O_res_h)); end
        tick();
    endtask

    task automatic test_window_back_to_back();
        for (int i = 0; i < 9; i++) begin
            send(mkp(-10, 15), (i == 0), (i == 8));
        end
        send(mkp(5, 3), 1'b1, 1'b1);
        checks++; if ($signed(O_res_l) !== 24'sd135 || O_res_valid !== 1'b1) begin errors++; $display("FAIL win_res_l: got %0d (valid %b) want 135", $signed(O_res_l), O_res_valid); end
        checks++; if ($signed(O_res_h) !== -24'sd90) begin errors++; $display("FAIL win_res_h: got %0d want -90", $signed(O_res_h)); end
        tick();
        checks++; if ($signed(O_res_l) !== 24'sd3 || O_res_valid !== 1'b1) begin errors++; $display("FAIL b2b_res_l: got %0d (valid %b) want 3", $signed(O_res_l), O_res_valid); end
        checks++; if ($signed(O_res_h) !== 24'sd5) begin errors++; $display("FAIL b2b_res_h: got %0d want 5", $signed(O_res_h)); end
        tick();
    endtask

    task automatic test_width();
        logic signed [23:0] exp_l;
`ifdef DSP_UNPACK_SAT_EN
        exp_l = 24'sd8388607;
`else
        exp_l = -24'sd7340232;
`endif
        for (int i = 0; i < 200; i++) begin
            send(mkp(0, 131071), (i == 0), (i == 199));
        end
        tick();
        checks++; if ($signed(O_res_l) !== exp_l) begin errors++; $display("FAIL width_res_l: got %0d want %0d", $signed(O_res_l), exp_l); end
        checks++; if ($signed(O_res_h) !== 24'sd0) begin errors++; $display("FAIL width_res_h: got %0d want 0", $signed(O_res_h)); end
        tick();
    endtask

    task automatic test_backpressure();
        I_res_ready = 1'b0;
        send(mkp(1, 2), 1'b1, 1'b1);
        send(mkp(3, 4), 1'b1, 1'b1);
        send(mkp(5, 6), 1'b1, 1'b1);
        checks++; if (O_ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_early: got %b want 0", O_ovf); end
        tick();
        checks++; if (O_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", O_ovf); end
        checks++; if (O_res_valid !== 1'b1 || $signed(O_res_l) !== 24'sd2 || $signed(O_res_h) !== 24'sd1) begin
            errors++; $display("FAIL bp_head0: got valid=%b l=%0d h=%0d want 1/2/1", O_res_valid, $signed(O_res_l), $signed(O_res_h)); end
        I_res_ready = 1'b1;
        tick();
        checks++; if (O_res_valid !== 1'b1 || $signed(O_res_l) !== 24'sd4 || $signed(O_res_h) !== 24'sd3) begin
            errors++; $display("FAIL bp_head1: got valid=%b l=%0d h=%0d want 1/4/3", O_res_valid, $signed(O_res_l), $signed(O_res_h)); end
        tick();
        checks++; if (O_res_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid=%b want 0", O_res_valid); end
        checks++; if (O_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", O_ovf); end
    endtask

    task automatic test_full_push_pop();
        I_res_ready = 1'b0;
        send(mkp(11, 12), 1'b1, 1'b1);
        send(mkp(13, 14), 1'b1, 1'b1);
        send(mkp(15, 16), 1'b1, 1'b1);
        checks++; if (O_res_valid !== 1'b1 || $signed(O_res_l) !== 24'sd12) begin
            errors++; $display("FAIL fpp_head0: got valid=%b l=%0d want 1/12", O_res_valid, $signed(O_res_l)); end
        I_res_ready = 1'b1;
        tick();
        checks++; if (O_res_valid !== 1'b1 || $signed(O_res_l) !== 24'sd14 || $signed(O_res_h) !== 24'sd13) begin
            errors++; $display("FAIL fpp_head1: got valid=%b l=%0d h=%0d want 1/14/13", O_res_valid, $signed(O_res_l), $signed(O_res_h)); end
        tick();
        checks++; if (O_res_valid !== 1'b1 || $signed(O_res_l) !== 24'sd16 || $signed(O_res_h) !== 24'sd15) begin
            errors++; $display("FAIL fpp_head2: got valid=%b l=%0d h=%0d want 1/16/15", O_res_valid, $signed(O_res_l), $signed(O_res_h)); end
        tick();
        checks++; if (O_res_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained: got valid=%b want 0", O_res_valid); end
    endtask

    task automatic test_reset_mid_window();
        I_res_ready = 1'b0;
        send(mkp(7, 8), 1'b1, 1'b1);
        send(mkp(100, 200), 1'b1, 1'b0);
        send(mkp(100, 200), 1'b0, 1'b0);
        checks++; if (O_res_valid !== 1'b1) begin errors++; $display("FAIL rmid_queued: got valid=%b want 1", O_res_valid); end
        I_rst_n = 1'b0;
        #1;
        checks++; if (O_res_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", O_res_valid); end
        checks++; if (O_ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %b want 0", O_ovf); end
        checks++; if (O_res_l !== 24'd0 || O_res_h !== 24'd0) begin errors++; $display("FAIL rmid_res: got l=%0d h=%0d want 0/0", O_res_l, O_res_h); end
        tick();
        I_rst_n     = 1'b1;
        I_res_ready = 1'b1;
        tick();
        send(mkp(-3, -4), 1'b0, 1'b1);
        tick();
        checks++; if (O_res_valid !== 1'b1 || $signed(O_res_l) !== -24'sd4 || $signed(O_res_h) !== -24'sd3) begin
            errors++; $display("FAIL rmid_fresh: got valid=%b l=%0d h=%0d want 1/-4/-3", O_res_valid, $signed(O_res_l), $signed(O_res_h)); end
        tick();
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        I_rst_n     = 1'b0;
        I_p         = '0;
        I_p_valid   = 1'b0;
        I_first     = 1'b0;
        I_last      = 1'b0;
        I_res_ready = 1'b1;
        #1;
        test_reset();
        test_unpack_pos();
        test_unpack_borrow();
        test_window_back_to_back();
        test_width();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_unpack_acc.md
# dsp_unpack_acc

Downstream stage of the packed dual-weight DSP multiply unit. Each valid 48-bit P word carries two products, `w_h*f` at bit offset SHIFT and `w_l*f` below it. This block splits the word into two signed products and accumulates each over a kernel window delimited by first/last markers. Finished result pairs go into a small output FIFO with a valid/ready handshake toward the result writer.

## Interface
- SHIFT, 18: bit position of the high product inside P; low field is P[SHIFT-1:0]
- ACC_W, 32: signed accumulator width, per lane
- OUT_W, 24: signed result width, per lane
- FIFO_DEPTH, 2: output FIFO entries (power of two, ≥2)
- I_clk  in  1  clock
- I_rst_n  in  1  asynchronous active-low reset
- I_p  in  48  packed product word from the DSP P output
- I_p_valid  in  1  I_p valid this cycle; upstream aligns it to DSP latency
- I_first  in  1  first term of a window (qualified by I_p_valid)
- I_last  in  1  last term of a window (qualified by I_p_valid)
- O_res_l  out  OUT_W  low-lane result
- O_res_h  out  OUT_W  high-lane result
- O_res_valid  out  1  FIFO head valid
- I_res_ready  in  1  consumer accepts head
- O_ovf  out  1  sticky: a result was dropped on a full FIFO

## Operation
- Unpack: lo = sign-extend(P[SHIFT-1:0]); hi = signed(P[47:SHIFT]) + P[SHIFT-1]. The added bit is borrow correction for a negative low field. Both are sign-extended to ACC_W.
- Accumulate per lane. On valid&first: acc = term, which discards any prior partial sum. On valid&!first: acc += term. Accumulation wraps at ACC_W with no overflow detection.
- valid&first&last forms a single-term window.
- Valid without a preceding first after reset adds onto the reset value 0.
- On valid&last: the final sum (acc + term, or term when first is also set) is converted to OUT_W and enqueued. The accumulator keeps that sum until the next first.
- Enqueue when FIFO full and no dequeue in the same cycle: the result is dropped and O_ovf is set. O_ovf clears only on reset.
- Full with a simultaneous dequeue and enqueue: both occur and nothing is lost.
- Dequeue on O_res_valid & I_res_ready. Order is FIFO. Outputs show the head entry and are undefined-but-stable when empty.
- There is no input backpressure; the DSP pipeline never stalls.

## Timing
- Stage 1 registers lo, hi, valid, first, last at the edge after cycle t.
- Stage 2 updates the accumulators and enqueues at the next edge.
- O_res_valid rises in cycle t+2 for last at cycle t when the FIFO is empty. Fall-through from the FIFO adds no cycle.
- Throughput is one P word per cycle. Back-to-back windows (last at t, first at t+1) are supported.
- Reset values: O_res_valid=0, O_ovf=0, O_res_l=O_res_h=0, accumulators=0, pipeline valids=0, FIFO empty.
- Reset mid-window discards the partial sums and all queued results.

## Configuration
- DSP_UNPACK_SAT_EN defined: ACC_W to OUT_W conversion saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], per lane.
- DSP_UNPACK_SAT_EN undefined: the conversion keeps the low OUT_W bits (two's-complement wrap).
- Accumulators are unaffected in either case.

## Structure
- Package dsp_pkg holds:
  - SHIFT, ACC_W and OUT_W defaults
  - the P width constant (48)
  - the unpack function returning the {hi, lo} pair
  - the saturate/truncate function
- Sub-module dsp_res_fifo: a synchronous FIFO parameterised by width (2*OUT_W) and depth, exposing full, empty, push and pop.

## Test plan
- Unpack, positive fields: P = (-10<<18)+15, one single-term window (first&last) → res_l=15, res_h=-10 at t+2.
- Unpack, borrow case: P = (-10<<18)-15, single-term window → res_l=-15, res_h=-10.
- Window: 9 words of (lo=15, hi=-10), first on word 1, last on word 9, followed immediately by a new window → first result res_l=135, res_h=-90; second window starts clean.
- Width boundary: 200 words with lo=131071 → with DSP_UNPACK_SAT_EN res_l=8388607; without it res_l=-7340232.
- Backpressure: I_res_ready=0, three consecutive single-term windows with distinct values → two held in order, third dropped, O_ovf=1. Raising ready drains the two held results in order. Also check a full FIFO with simultaneous push/pop loses nothing.
- Reset: assert I_rst_n=0 mid-window with one result queued → all outputs 0, FIFO empty, O_ovf=0. A following window accumulates from zero.
